// File: rtl/vending_controller_param_pkg.sv
// Shared definitions for the parametrised vending controller: default
// machine dimensions, FSM state encoding and a small width helper.
package vending_controller_param_pkg;

    localparam int unsigned K_NUM_COINS  = 3;
    localparam int unsigned K_NUM_ITEMS  = 4;
    localparam int unsigned K_TOTAL_BITS = 31;
    localparam int unsigned VALUE_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_RETURN = 2'd2
    } vend_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vending_controller_param_change_select.sv
// Greedy change selector: picks the largest coin whose value fits into the
// remaining credit. Coin values are ascending in k, so the last fitting
// index in an ascending scan is the largest coin.
module vending_change_select
    import vending_controller_param_pkg::*;
#(
    parameter int unsigned NUM_COINS = K_NUM_COINS,
    parameter int unsigned CW        = 32
) (
    input  logic [CW-1:0]                credit_i,
    input  logic [NUM_COINS*VALUE_W-1:0] value_i,
    output logic [NUM_COINS-1:0]         coin_o,
    output logic [VALUE_W-1:0]           value_o,
    output logic                         valid_o
);

    // Scan ascending; a later fitting coin overrides an earlier one.
    always_comb begin
        coin_o  = '0;
        value_o = '0;
        valid_o = 1'b0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (CW'(value_i[VALUE_W*k +: VALUE_W]) <= credit_i) begin
                coin_o    = '0;
                coin_o[k] = 1'b1;
                value_o   = value_i[VALUE_W*k +: VALUE_W];
                valid_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vending_controller_param.sv
// Parametrised vending controller: credit accumulation with overflow
// rejection, per-item stock, inactivity timeout and greedy change return.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | credit is 0, waiting for coins
// ST_ACCEPT | credit > 0, coins/selects/return accepted, timer running
// ST_RETURN | paying out change one coin per cycle, busy
module vending_controller_param
    import vending_controller_param_pkg::*;
#(
    parameter int unsigned NUM_COINS   = K_NUM_COINS,
    parameter int unsigned NUM_ITEMS   = K_NUM_ITEMS,
    parameter int unsigned TOTAL_BITS  = K_TOTAL_BITS,
    parameter int unsigned WAIT_CYCLES = 100,
    parameter int unsigned STOCK_BITS  = 4,
    parameter int unsigned INIT_STOCK  = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_COINS-1:0]          i_input_coin,
    input  logic [NUM_ITEMS-1:0]          i_select_item,
    input  logic                          i_trigger_return,
    input  logic                          i_restock,
    input  logic [NUM_COINS*VALUE_W-1:0]  i_coin_value,
    input  logic [NUM_ITEMS*VALUE_W-1:0]  i_item_price,
    output logic [TOTAL_BITS-1:0]         o_current_total,
    output logic [NUM_ITEMS-1:0]          o_available_item,
    output logic [NUM_ITEMS-1:0]          o_output_item,
    output logic [NUM_COINS-1:0]          o_return_coin,
    output logic                          o_coin_reject,
    output logic                          o_busy
);

    // Comparison width: credit and 32-bit values are both zero-extended to this.
    localparam int unsigned CW = max_u(VALUE_W, TOTAL_BITS);
    // Sum width: room for the credit plus every coin inserted at once.
    localparam int unsigned SW = CW + $clog2(NUM_COINS) + 1;
    localparam int unsigned TW = $clog2(WAIT_CYCLES + 1);

    localparam logic [TW-1:0]         TIMER_RELOAD = TW'(WAIT_CYCLES);
    localparam logic [STOCK_BITS-1:0] STOCK_RELOAD = STOCK_BITS'(INIT_STOCK);
    localparam logic [SW-1:0]         CREDIT_MAX   = {{(SW-TOTAL_BITS){1'b0}}, {TOTAL_BITS{1'b1}}};

    vend_state_e                          state_q, state_d;
    logic [TOTAL_BITS-1:0]                credit_q, credit_d;
    logic [TW-1:0]                        timer_q, timer_d;
    logic [NUM_ITEMS-1:0][STOCK_BITS-1:0] stock_q, stock_d;
    logic [NUM_ITEMS-1:0]                 item_q, item_d;
    logic [NUM_COINS-1:0]                 ret_q, ret_d;
    logic                                 reject_q, reject_d;

    logic [SW-1:0]        coin_sum;
    logic [SW-1:0]        sum_ext;
    logic                 any_coin;
    logic                 coin_ovf;
    logic                 coin_ok;
    logic [NUM_ITEMS-1:0] avail;
    logic [NUM_ITEMS-1:0] sel_oh;
    logic [VALUE_W-1:0]   price_sel;
    logic                 dispense;
    logic [SW-1:0]        base;
    logic [NUM_COINS-1:0] chg_oh;
    logic [VALUE_W-1:0]   chg_val;
    logic                 chg_valid;
    logic [TOTAL_BITS-1:0] chg_remain;

    vending_change_select #(
        .NUM_COINS (NUM_COINS),
        .CW        (CW)
    ) u_change_select (
        .credit_i (CW'(credit_q)),
        .value_i  (i_coin_value),
        .coin_o   (chg_oh),
        .value_o  (chg_val),
        .valid_o  (chg_valid)
    );

    // Coin sum of this cycle and the overflow test against the credit ceiling.
    always_comb begin
        coin_sum = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (i_input_coin[k]) begin
                coin_sum = coin_sum + SW'(i_coin_value[VALUE_W*k +: VALUE_W]);
            end
        end
        any_coin = |i_input_coin;
        sum_ext  = SW'(credit_q) + coin_sum;
        coin_ovf = (sum_ext > CREDIT_MAX);
        coin_ok  = any_coin && !coin_ovf;
    end

    // Item availability from registered credit/stock; blanked while returning.
    always_comb begin
        avail = '0;
        for (int j = 0; j < NUM_ITEMS; j++) begin
            avail[j] = (state_q != ST_RETURN)
                    && (CW'(credit_q) >= CW'(i_item_price[VALUE_W*j +: VALUE_W]))
                    && (stock_q[j] != '0);
        end
    end

    // Lowest-index select wins; a winning but unavailable item is simply ignored.
    always_comb begin
        sel_oh    = i_select_item & (~i_select_item + NUM_ITEMS'(1));
        price_sel = '0;
        for (int j = 0; j < NUM_ITEMS; j++) begin
            if (sel_oh[j]) begin
                price_sel = i_item_price[VALUE_W*j +: VALUE_W];
            end
        end
        dispense = |(sel_oh & avail);
        base     = coin_ok ? sum_ext : SW'(credit_q);
        if (dispense) begin
            base = base - SW'(price_sel);
        end
        // chg_val never exceeds credit, so the resize is lossless.
        chg_remain = credit_q - TOTAL_BITS'(chg_val);
    end

    // Next-state and next-output logic for the controller FSM.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        timer_d  = timer_q;
        stock_d  = stock_q;
        item_d   = '0;
        ret_d    = '0;
        reject_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (any_coin) begin
                    if (coin_ovf) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = sum_ext[TOTAL_BITS-1:0];
                        timer_d  = TIMER_RELOAD;
                        if (sum_ext != '0) begin
                            state_d = ST_ACCEPT;
                        end
                    end
                end
            end

            ST_ACCEPT: begin
                if (i_trigger_return) begin
                    state_d  = ST_RETURN;
                    reject_d = any_coin;
                end else begin
                    reject_d = any_coin && coin_ovf;
                    credit_d = base[TOTAL_BITS-1:0];
                    if (dispense) begin
                        item_d = sel_oh;
                        for (int j = 0; j < NUM_ITEMS; j++) begin
                            if (sel_oh[j]) begin
                                stock_d[j] = stock_q[j] - STOCK_BITS'(1);
                            end
                        end
                    end
                    if (coin_ok || dispense) begin
                        timer_d = TIMER_RELOAD;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                    if (base == '0) begin
                        state_d = ST_IDLE;
                        timer_d = TIMER_RELOAD;
                    end else if (!coin_ok && !dispense && timer_q <= TW'(1)) begin
                        state_d = ST_RETURN;
                        timer_d = '0;
                    end
                end
            end

            ST_RETURN: begin
                reject_d = any_coin;
                if (chg_valid) begin
                    ret_d    = chg_oh;
                    credit_d = chg_remain;
                    if (chg_remain == '0) begin
                        state_d = ST_IDLE;
                        timer_d = TIMER_RELOAD;
                    end
                end else begin
                    // Residue smaller than the smallest coin is forfeited.
                    credit_d = '0;
                    state_d  = ST_IDLE;
                    timer_d  = TIMER_RELOAD;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
                timer_d  = TIMER_RELOAD;
            end
        endcase

        // Restock wins over any same-cycle decrement.
        if (i_restock) begin
            for (int j = 0; j < NUM_ITEMS; j++) begin
                stock_d[j] = STOCK_RELOAD;
            end
        end
    end

    // State, credit, timer, stock and registered pulse outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            timer_q  <= TIMER_RELOAD;
            for (int j = 0; j < NUM_ITEMS; j++) begin
                stock_q[j] <= STOCK_RELOAD;
            end
            item_q   <= '0;
            ret_q    <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            stock_q  <= stock_d;
            item_q   <= item_d;
            ret_q    <= ret_d;
            reject_q <= reject_d;
        end
    end

    assign o_current_total  = credit_q;
    assign o_available_item = avail;
    assign o_output_item    = item_q;
    assign o_return_coin    = ret_q;
    assign o_coin_reject    = reject_q;
    assign o_busy           = (state_q == ST_RETURN);

endmodule

// File: tb/tb_vending_controller_param.sv
// Directed bench: two controller instances (31-bit credit / stock 8, and
// 10-bit credit / stock 1), coins 100/500/1000, prices 400/500/1000/2000.
module tb_vending_controller_param;

    localparam logic [95:0]  VALUES = {32'd1000, 32'd500, 32'd100};
    localparam logic [127:0] PRICES = {32'd2000, 32'd1000, 32'd500, 32'd400};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A
    logic        rst_a_n;
    logic [2:0]  coin_a;
    logic [3:0]  sel_a;
    logic        trig_a, restock_a;
    logic [30:0] total_a;
    logic [3:0]  avail_a, item_a;
    logic [2:0]  ret_a;
    logic        rej_a, busy_a;

    // Instance B
    logic        rst_b_n;
    logic [2:0]  coin_b;
    logic [3:0]  sel_b;
    logic        trig_b, restock_b;
    logic [9:0]  total_b;
    logic [3:0]  avail_b, item_b;
    logic [2:0]  ret_b;
    logic        rej_b, busy_b;

    vending_controller_param #(
        .NUM_COINS(3), .NUM_ITEMS(4), .TOTAL_BITS(31),
        .WAIT_CYCLES(10), .STOCK_BITS(4), .INIT_STOCK(8)
    ) dut_a (
        .clk(clk), .reset_n(rst_a_n),
        .i_input_coin(coin_a), .i_select_item(sel_a),
        .i_trigger_return(trig_a), .i_restock(restock_a),
        .i_coin_value(VALUES), .i_item_price(PRICES),
        .o_current_total(total_a), .o_available_item(avail_a),
        .o_output_item(item_a), .o_return_coin(ret_a),
        .o_coin_reject(rej_a), .o_busy(busy_a)
    );

    vending_controller_param #(
        .NUM_COINS(3), .NUM_ITEMS(4), .TOTAL_BITS(10),
        .WAIT_CYCLES(10), .STOCK_BITS(4), .INIT_STOCK(1)
    ) dut_b (
        .clk(clk), .reset_n(rst_b_n),
        .i_input_coin(coin_b), .i_select_item(sel_b),
        .i_trigger_return(trig_b), .i_restock(restock_b),
        .i_coin_value(VALUES), .i_item_price(PRICES),
        .o_current_total(total_b), .o_available_item(avail_b),
        .o_output_item(item_b), .o_return_coin(ret_b),
        .o_coin_reject(rej_b), .o_busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        coin_a = '0; sel_a = '0; trig_a = 1'b0; restock_a = 1'b0;
        coin_b = '0; sel_b = '0; trig_b = 1'b0; restock_b = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        #12;
        check_eq("rst_total_a", 32'(total_a), 0);
        check_eq("rst_avail_a", 32'(avail_a), 0);
        check_eq("rst_item_a",  32'(item_a), 0);
        check_eq("rst_ret_a",   32'(ret_a), 0);
        check_eq("rst_busy_a",  32'(busy_a), 0);
        check_eq("rst_rej_a",   32'(rej_a), 0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        tick();

        // 1: 500 then 1000 -> 1500, buy item1
        coin_a = 3'b010; tick();
        check_eq("t1_total500", 32'(total_a), 500);
        coin_a = 3'b100; tick(); coin_a = '0;
        check_eq("t1_total1500", 32'(total_a), 1500);
        check_eq("t1_avail", 32'(avail_a), 32'b0111);
        sel_a = 4'b0010; tick(); sel_a = '0;
        check_eq("t1_item", 32'(item_a), 32'b0010);
        check_eq("t1_total_after", 32'(total_a), 1000);
        tick();
        check_eq("t1_item_cleared", 32'(item_a), 0);

        // 2: reach 1600 with two coins at once, then return change
        coin_a = 3'b011; tick(); coin_a = '0;
        check_eq("t2_total1600", 32'(total_a), 1600);
        trig_a = 1'b1; tick(); trig_a = 1'b0;
        check_eq("t2_busy_enter", 32'(busy_a), 1);
        check_eq("t2_avail_ret", 32'(avail_a), 0);
        check_eq("t2_no_ret_yet", 32'(ret_a), 0);
        tick();
        check_eq("t2_ret1000", 32'(ret_a), 32'b100);
        check_eq("t2_busy1", 32'(busy_a), 1);
        check_eq("t2_total600", 32'(total_a), 600);
        tick();
        check_eq("t2_ret500", 32'(ret_a), 32'b010);
        check_eq("t2_busy2", 32'(busy_a), 1);
        tick();
        check_eq("t2_ret100", 32'(ret_a), 32'b001);
        check_eq("t2_total0", 32'(total_a), 0);
        check_eq("t2_idle", 32'(busy_a), 0);
        tick();
        check_eq("t2_ret_cleared", 32'(ret_a), 0);

        // 3: timeout on the 10th idle edge
        coin_a = 3'b001; tick(); coin_a = '0;
        check_eq("t3_total100", 32'(total_a), 100);
        for (int i = 0; i < 9; i++) tick();
        check_eq("t3_not_yet", 32'(busy_a), 0);
        tick();
        check_eq("t3_timeout", 32'(busy_a), 1);
        tick();
        check_eq("t3_ret", 32'(ret_a), 32'b001);
        check_eq("t3_total0", 32'(total_a), 0);
        check_eq("t3_idle", 32'(busy_a), 0);

        // 5a: 400 credit, coin 500 + select item0 together -> 500
        for (int i = 0; i < 4; i++) begin
            coin_a = 3'b001; tick();
        end
        coin_a = '0;
        check_eq("t5_total400", 32'(total_a), 400);
        coin_a = 3'b010; sel_a = 4'b0001; tick(); coin_a = '0; sel_a = '0;
        check_eq("t5_item0", 32'(item_a), 32'b0001);
        check_eq("t5_total500", 32'(total_a), 500);
        check_eq("t5_no_reject", 32'(rej_a), 0);

        // 6a: async reset in the middle of a return
        coin_a = 3'b111; tick(); coin_a = '0;
        check_eq("t6_total2100", 32'(total_a), 2100);
        trig_a = 1'b1; tick(); trig_a = 1'b0;
        tick();
        check_eq("t6_ret1000", 32'(ret_a), 32'b100);
        #2 rst_a_n = 1'b0;
        #1;
        check_eq("t6_rst_total", 32'(total_a), 0);
        check_eq("t6_rst_busy", 32'(busy_a), 0);
        check_eq("t6_rst_ret", 32'(ret_a), 0);
        rst_a_n = 1'b1;
        tick();

        // 4: stock of one, second purchase refused, restock recovers
        coin_b = 3'b100; tick(); coin_b = '0;
        check_eq("t4_total1000", 32'(total_b), 1000);
        check_eq("t4_avail", 32'(avail_b), 32'b0111);
        sel_b = 4'b0001; tick(); sel_b = '0;
        check_eq("t4_buy1", 32'(item_b), 32'b0001);
        check_eq("t4_total600", 32'(total_b), 600);
        tick();
        sel_b = 4'b0001; tick(); sel_b = '0;
        check_eq("t4_buy2_none", 32'(item_b), 0);
        check_eq("t4_total_kept", 32'(total_b), 600);
        check_eq("t4_avail_empty", 32'(avail_b), 32'b0010);
        restock_b = 1'b1; tick(); restock_b = 1'b0;
        check_eq("t4_restocked", 32'(avail_b), 32'b0011);

        // overflow: 600 + 1000 exceeds 1023
        coin_b = 3'b100; tick(); coin_b = '0;
        check_eq("t4_reject", 32'(rej_b), 1);
        check_eq("t4_total_rej", 32'(total_b), 600);
        tick();
        check_eq("t4_reject_pulse", 32'(rej_b), 0);

        // 5b: drain, then 500 + 1000 rejected
        trig_b = 1'b1; tick(); trig_b = 1'b0;
        tick();
        check_eq("t5b_ret500", 32'(ret_b), 32'b010);
        tick();
        check_eq("t5b_ret100", 32'(ret_b), 32'b001);
        check_eq("t5b_total0", 32'(total_b), 0);
        coin_b = 3'b010; tick();
        check_eq("t5b_total500", 32'(total_b), 500);
        coin_b = 3'b100; tick(); coin_b = '0;
        check_eq("t5b_reject", 32'(rej_b), 1);
        check_eq("t5b_total_kept", 32'(total_b), 500);

        // 6b: reset restores stock
        sel_b = 4'b0001; tick(); sel_b = '0;
        check_eq("t6b_buy", 32'(item_b), 32'b0001);
        check_eq("t6b_total100", 32'(total_b), 100);
        coin_b = 3'b010; tick(); coin_b = '0;
        check_eq("t6b_sold_out", 32'(avail_b), 32'b0010);
        #2 rst_b_n = 1'b0;
        #1;
        check_eq("t6b_rst_total", 32'(total_b), 0);
        rst_b_n = 1'b1;
        tick();
        coin_b = 3'b010; tick(); coin_b = '0;
        check_eq("t6b_stock_back", 32'(avail_b), 32'b0011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
